// File: rtl/mem_router_pkg.sv
// mem_router_pkg: bus widths, request counts, response codes and access-size helper.
package mem_router_pkg;
    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int MEM_COUNT_W = 2;
    localparam int MEM_CODE_W = 2;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_NONE = 2'd0;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ = 2'd1;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE = 2'd2;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID = 2'd3;

    function automatic logic [2:0] mem_size(input logic [MEM_COUNT_W-1:0] count);
        return count == MEM_COUNT_WORD ? 3'd4 : count == MEM_COUNT_HALF ? 3'd2 : 3'd1;
    endfunction
endpackage

// File: rtl/mem_region_decode.sv
// mem_region_decode: full-containment hit and alignment check of one access against one region.
module mem_region_decode
    import mem_router_pkg::*;
#(
    parameter int unsigned START = 0,
    parameter int unsigned SIZE = 4096
) (
    input  logic [ADDR_W-1:0]      addr,
    input  logic [MEM_COUNT_W-1:0] count,
    output logic                   hit,
    output logic                   misaligned
);
    logic [ADDR_W:0] lo, hi, last;
    // one extra bit so region ends and access ends at the top of the map never wrap
    assign lo = (ADDR_W+1)'(START);
    assign hi = lo + (ADDR_W+1)'(SIZE);
    assign last = {1'b0, addr} + (ADDR_W+1)'(mem_size(count));
    assign hit = {1'b0, addr} >= lo && last <= hi;
    assign misaligned = (count == MEM_COUNT_HALF && addr[0]) || (count == MEM_COUNT_WORD && addr[1:0] != 2'd0);
endmodule

// File: rtl/mem_router.sv
// mem_router: routes master requests to RAM or GPIO, returns the 1-cycle response and tracks faults.
module mem_router
    import mem_router_pkg::*;
#(
    parameter int unsigned RAM_ADDR_START = 0,
    parameter int unsigned RAM_SIZE = 4096,
    parameter int unsigned GPIO_ADDR_START = 'h8000,
    parameter int unsigned GPIO_BANK_COUNT = 4
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [ADDR_W-1:0]      i_req_addr,
    input  logic [WORD_W-1:0]      i_req_wr_data,
    input  logic                   i_req_wr_en,
    input  logic [MEM_COUNT_W-1:0] i_req_count,
    output logic [WORD_W-1:0]      o_res_rd_data,
    output logic [MEM_CODE_W-1:0]  o_res_code,
    output logic [ADDR_W-1:0]      o_ram_req_addr,
    output logic [WORD_W-1:0]      o_ram_req_wr_data,
    output logic                   o_ram_req_wr_en,
    output logic [MEM_COUNT_W-1:0] o_ram_req_count,
    output logic [ADDR_W-1:0]      o_gpio_req_addr,
    output logic [WORD_W-1:0]      o_gpio_req_wr_data,
    output logic                   o_gpio_req_wr_en,
    output logic [MEM_COUNT_W-1:0] o_gpio_req_count,
    input  logic [WORD_W-1:0]      i_ram_res_rd_data,
    input  logic [MEM_CODE_W-1:0]  i_ram_res_code,
    input  logic [WORD_W-1:0]      i_gpio_res_rd_data,
    input  logic [MEM_CODE_W-1:0]  i_gpio_res_code,
    output logic                   o_fault,
    output logic [ADDR_W-1:0]      o_fault_addr,
    output logic [7:0]             o_fault_cnt,
    input  logic                   i_fault_clr
);
    localparam logic [1:0] T_NONE = 2'd0;
    localparam logic [1:0] T_RAM = 2'd1;
    localparam logic [1:0] T_GPIO = 2'd2;
    localparam logic [1:0] T_ERR = 2'd3;

    logic ram_hit, ram_mis, gpio_hit, gpio_mis;
    logic active, ram_ok, gpio_ok, err;
    logic [1:0] target;

    mem_region_decode #(.START(RAM_ADDR_START), .SIZE(RAM_SIZE)) u_ram_dec (
        .addr(i_req_addr), .count(i_req_count), .hit(ram_hit), .misaligned(ram_mis)
    );
    mem_region_decode #(.START(GPIO_ADDR_START), .SIZE(GPIO_BANK_COUNT)) u_gpio_dec (
        .addr(i_req_addr), .count(i_req_count), .hit(gpio_hit), .misaligned(gpio_mis)
    );

    assign active = i_req_count != MEM_COUNT_NONE;
    assign ram_ok = active && ram_hit && !ram_mis;
    // an overlap of both regions goes to RAM
    assign gpio_ok = active && gpio_hit && !ram_hit && !gpio_mis;
    assign err = active && !ram_ok && !gpio_ok;

    assign o_ram_req_addr = i_req_addr - ADDR_W'(RAM_ADDR_START);
    assign o_ram_req_wr_data = i_req_wr_data;
    assign o_ram_req_wr_en = ram_ok && i_req_wr_en;
    assign o_ram_req_count = ram_ok ? i_req_count : MEM_COUNT_NONE;
    assign o_gpio_req_addr = i_req_addr - ADDR_W'(GPIO_ADDR_START);
    assign o_gpio_req_wr_data = i_req_wr_data;
    assign o_gpio_req_wr_en = gpio_ok && i_req_wr_en;
    assign o_gpio_req_count = gpio_ok ? i_req_count : MEM_COUNT_NONE;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            target <= T_NONE;
        else
            target <= !active ? T_NONE : ram_ok ? T_RAM : gpio_ok ? T_GPIO : T_ERR;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            o_fault <= 1'b0;
            o_fault_addr <= '0;
            o_fault_cnt <= '0;
        end else if (i_fault_clr) begin
            o_fault <= 1'b0;
            o_fault_addr <= '0;
            o_fault_cnt <= '0;
        end else if (err) begin
            o_fault <= 1'b1;
            o_fault_addr <= o_fault ? o_fault_addr : i_req_addr;
            o_fault_cnt <= o_fault_cnt == 8'hff ? o_fault_cnt : o_fault_cnt + 8'd1;
        end
    end

    assign o_res_rd_data = target == T_RAM ? i_ram_res_rd_data : target == T_GPIO ? i_gpio_res_rd_data : '0;
    assign o_res_code = target == T_RAM ? i_ram_res_code : target == T_GPIO ? i_gpio_res_code :
                        target == T_ERR ? MEM_CODE_INVALID : MEM_CODE_NONE;
endmodule

// File: doc/mem_router.md
MEM_ROUTER -- requirements
Module: mem_router

Interface
REQ-001 SHALL have parameter RAM_ADDR_START, default 0, meaning the first byte address of the RAM region.
REQ-002 SHALL have parameter RAM_SIZE, default 4096, meaning the RAM region length in bytes.
REQ-003 SHALL have parameter GPIO_ADDR_START, default 'h8000, meaning the first byte address of the GPIO region.
REQ-004 SHALL have parameter GPIO_BANK_COUNT, default 4, meaning the GPIO region length in bytes (one byte per bank).
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk in 1 (system clock); aresetn in 1 (async active-low reset).
REQ-006 SHALL have master inputs: i_req_addr in ADDR_W; i_req_wr_data in WORD_W; i_req_wr_en in 1; i_req_count in MEM_COUNT_W.
REQ-007 SHALL have master outputs: o_res_rd_data out WORD_W; o_res_code out MEM_CODE_W.
REQ-008 SHALL have per-slave request outputs o_ram_req_{addr,wr_data,wr_en,count} and o_gpio_req_{addr,wr_data,wr_en,count}, with the same widths as the master request.
REQ-009 SHALL have per-slave response inputs i_ram_res_{rd_data,code} and i_gpio_res_{rd_data,code}, with the same widths as the master response.
REQ-010 SHALL have fault outputs: o_fault out 1 (sticky fault flag); o_fault_addr out ADDR_W (first faulting address); o_fault_cnt out 8 (saturating fault count).
REQ-011 SHALL have i_fault_clr in 1, meaning a synchronous clear of all fault state.

Function
REQ-012 SHALL treat a request as active when i_req_count != MEM_COUNT_NONE.
REQ-013 SHALL decode combinationally: RAM hit when addr..addr+size-1 lies fully in [RAM_ADDR_START, RAM_ADDR_START+RAM_SIZE); GPIO hit likewise for its region; size is 1, 2 or 4 bytes for BYTE, HALF, WORD.
REQ-014 SHALL mark a request misaligned when HALF has addr[0]=1 or WORD has addr[1:0]!=0.
REQ-015 SHALL forward a valid hit to exactly one slave in the same cycle with the address rebased (addr minus region start); every other slave SHALL see count=MEM_COUNT_NONE, wr_en=0.
REQ-016 SHALL forward nothing (all slaves NONE) for an unmapped or misaligned request.
REQ-017 SHALL register the routing target (NONE/RAM/GPIO/ERR) on each clk edge, giving a response latency of exactly 1 cycle, matching the slaves.
REQ-018 SHALL, in the response cycle, drive the selected slave's rd_data and code unmodified to the master when the target is RAM or GPIO.
REQ-019 SHALL drive rd_data=0 and code=MEM_CODE_INVALID when the target is ERR.
REQ-020 SHALL drive rd_data=0 and code=MEM_CODE_NONE when the target is NONE.
REQ-021 SHALL accept back-to-back requests every cycle, with no stalls.
REQ-022 SHALL, on an ERR request: set o_fault; load o_fault_addr only if o_fault was 0 (first fault wins); increment o_fault_cnt, saturating at 255.
REQ-023 SHALL give i_fault_clr priority over a same-cycle fault: all fault state goes to 0 and the same-cycle fault is dropped.
REQ-024 SHALL route a request that overlaps both regions (misconfiguration) to RAM (RAM has priority).

Reset
REQ-025 SHALL, while aresetn=0, asynchronously force the target register to NONE, o_res_rd_data=0, o_res_code=MEM_CODE_NONE, o_fault=0, o_fault_addr=0, o_fault_cnt=0.
REQ-026 SHALL let a reset asserted mid-request discard that request's response; the first post-reset cycle reports MEM_CODE_NONE.
REQ-027 SHALL use no synchronous reset.

Structure
REQ-028 SHALL take ADDR_W, WORD_W and MEM_COUNT_* from config.vh/mem_codes.vh; MEM_CODE_NONE and MEM_CODE_INVALID SHALL be added to mem_codes.vh if absent.
REQ-029 SHALL keep the target encodings as localparams in the module.
REQ-030 SHALL implement the per-region hit/alignment check as one sub-module, mem_region_decode (params START, SIZE), instantiated twice.

Verification
REQ-031 SHALL test: after reset, WORD read at addr 0 -> next cycle o_res_code equals the RAM response code and the GPIO port sees NONE.
REQ-032 SHALL test: WORD write 'hdeadbeef at GPIO_ADDR_START -> o_gpio_req_addr=0 and wr_en=1 in the same cycle; next cycle o_res_code=MEM_CODE_WRITE.
REQ-033 SHALL test: HALF read at RAM addr 1 -> no slave request; next cycle MEM_CODE_INVALID, o_fault=1, o_fault_addr=1, o_fault_cnt=1.
REQ-034 SHALL test: WORD at GPIO_ADDR_START+2 (straddles the end) then an unmapped 'h4000 -> o_fault_addr stays GPIO_ADDR_START+2, o_fault_cnt=2.
REQ-035 SHALL test: 300 consecutive faults -> o_fault_cnt=255; then i_fault_clr together with a fault -> all fault outputs 0.
REQ-036 SHALL test: RAM read, GPIO read, NONE on three consecutive cycles -> responses appear in order, one cycle each; aresetn pulsed low mid-sequence -> next response MEM_CODE_NONE.
